// File: rtl/wishbone_arbiter_2m.sv
// Two-master round-robin Wishbone classic arbiter with a per-transfer ack timeout.
// Grant is one cycle after the request and is held until the owner drops cyc; acks pass through combinationally.
module wishbone_arbiter_2m #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] tcnt, tcnt_nxt;
    logic             m0_err_nxt, m1_err_nxt;
    logic             pick;
    logic             own_cyc, own_stb;

    assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner ? m1_stb_i : m0_stb_i;

    // Under contention the master not served last wins; otherwise the sole requester.
    assign pick = (m0_cyc_i && m1_cyc_i) ? ~last_grant : m1_cyc_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            tcnt       <= '0;
            m0_err_o   <= 1'b0;
            m1_err_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            tcnt       <= tcnt_nxt;
            m0_err_o   <= m0_err_nxt;
            m1_err_o   <= m1_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        tcnt_nxt       = tcnt;
        m0_err_nxt     = 1'b0;
        m1_err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                if (m0_cyc_i || m1_cyc_i) begin
                    state_nxt      = OWN;
                    owner_nxt      = pick;
                    last_grant_nxt = pick;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    tcnt_nxt  = '0;
                end else if (TO_EN && own_stb && !s_ack_i) begin
                    if (tcnt == TO_LAST) begin
                        state_nxt  = ABORT;
                        tcnt_nxt   = '0;
                        m0_err_nxt = ~owner;
                        m1_err_nxt = owner;
                    end else begin
                        tcnt_nxt = tcnt + CNT_W'(1);
                    end
                end else begin
                    tcnt_nxt = '0;
                end
            end
            ABORT: begin
                tcnt_nxt = '0;
                if (!own_cyc) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                tcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        grant_o  = 2'b00;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        if (state == OWN || state == ABORT) grant_o = owner ? 2'b10 : 2'b01;
        if (state == OWN) begin
            s_cyc_o  = own_cyc;
            s_stb_o  = own_stb;
            s_we_o   = owner ? m1_we_i   : m0_we_i;
            s_addr_o = owner ? m1_addr_i : m0_addr_i;
            s_data_o = owner ? m1_data_i : m0_data_i;
            m0_ack_o = s_ack_i & ~owner;
            m1_ack_o = s_ack_i & owner;
        end
    end

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Bench for wishbone_arbiter_2m: directed vector table, hand sequences for timeout corners, randomized run vs a reference model.
module tb_wishbone_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdat [2];
    logic          s_ack;
    logic [DW-1:0] s_rdat;

    logic [DW-1:0] m0_data_o, m1_data_o, s_data_o;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [1:0]    grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wishbone_arbiter_2m #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_addr_i(addr[0]), .m0_data_i(wdat[0]), .m0_data_o(m0_data_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_addr_i(addr[1]), .m1_data_i(wdat[1]), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_data_i(s_rdat), .s_ack_i(s_ack), .grant_o(grant_o)
    );

    typedef struct {
        bit        rst;
        bit [1:0]  cyc;
        bit [1:0]  stb;
        bit        ack;
        bit [1:0]  grant;
        bit        scyc;
        bit [31:0] saddr;
        bit [1:0]  acks;
    } vec_t;

    vec_t tbl [32];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit [1:0] c, input bit [1:0] s, input bit a);
        rst = r; cyc = c; stb = s; s_ack = a;
    endtask

    // end of cycle: let the edge happen, then move inputs away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit r, bit [1:0] c, bit [1:0] s, bit a,
                                bit [1:0] g, bit sc, bit [31:0] sa, bit [1:0] ak);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.ack = a;
        v.grant = g; v.scyc = sc; v.saddr = sa; v.acks = ak;
        return v;
    endfunction

    // reference model state: owner id (-1 none), abort flag, consecutive stalled beats
    int       m_own, m_last, m_wait;
    bit       m_abt;
    bit [1:0] m_err;

    initial begin
        tbl[0]  = mk(0, 2'b01, 2'b01, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[1]  = mk(0, 2'b01, 2'b01, 1, 2'b01, 1, 32'h10, 2'b01);
        tbl[2]  = mk(0, 2'b00, 2'b00, 0, 2'b01, 0, 32'h10, 2'b00);
        tbl[3]  = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[4]  = mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[5]  = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[6]  = mk(0, 2'b11, 2'b11, 1, 2'b01, 1, 32'h10, 2'b01);
        tbl[7]  = mk(0, 2'b10, 2'b10, 0, 2'b01, 0, 32'h10, 2'b00);
        tbl[8]  = mk(0, 2'b10, 2'b10, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[9]  = mk(0, 2'b11, 2'b11, 1, 2'b10, 1, 32'h20, 2'b10);
        tbl[10] = mk(0, 2'b01, 2'b01, 0, 2'b10, 0, 32'h20, 2'b00);
        tbl[11] = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[12] = mk(0, 2'b10, 2'b10, 0, 2'b01, 0, 32'h10, 2'b00);
        tbl[13] = mk(0, 2'b10, 2'b10, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[14] = mk(0, 2'b00, 2'b00, 0, 2'b10, 0, 32'h20, 2'b00);
        tbl[15] = mk(0, 2'b10, 2'b10, 0, 2'b00, 0, 32'h00, 2'b00);
        for (int i = 16; i < 20; i++)
            tbl[i] = mk(0, 2'b11, 2'b11, 1, 2'b10, 1, 32'h20, 2'b10);
        tbl[20] = mk(0, 2'b11, 2'b01, 0, 2'b10, 1, 32'h20, 2'b00);
        tbl[21] = mk(0, 2'b01, 2'b01, 0, 2'b10, 0, 32'h20, 2'b00);
        tbl[22] = mk(0, 2'b01, 2'b01, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[23] = mk(0, 2'b01, 2'b01, 1, 2'b01, 1, 32'h10, 2'b01);
        tbl[24] = mk(0, 2'b00, 2'b00, 0, 2'b01, 0, 32'h10, 2'b00);
        tbl[25] = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[26] = mk(0, 2'b10, 2'b10, 0, 2'b00, 0, 32'h00, 2'b00);
        tbl[27] = mk(1, 2'b11, 2'b11, 0, 2'b10, 1, 32'h20, 2'b00);
        tbl[28] = mk(0, 2'b11, 2'b11, 1, 2'b00, 0, 32'h00, 2'b00);
        tbl[29] = mk(0, 2'b11, 2'b11, 1, 2'b01, 1, 32'h10, 2'b01);
        tbl[30] = mk(0, 2'b00, 2'b00, 0, 2'b01, 0, 32'h10, 2'b00);
        tbl[31] = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 32'h00, 2'b00);

        we = 2'b01;
        addr[0] = 32'h10; addr[1] = 32'h20;
        wdat[0] = 64'hDEAD; wdat[1] = 64'hBEEF;
        s_rdat = 64'h1234_5678;

        // reset held with both masters requesting and a stray ack
        drive(1, 2'b11, 2'b11, 1);
        step(); step();
        @(negedge clk);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_slave", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o}, '0);
        chk("rst_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
        step();

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].ack);
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), grant_o, tbl[i].grant);
            chk($sformatf("vec%0d_scyc", i), s_cyc_o, tbl[i].scyc);
            chk($sformatf("vec%0d_saddr", i), s_addr_o, tbl[i].saddr);
            chk($sformatf("vec%0d_acks", i), {m1_ack_o, m0_ack_o}, tbl[i].acks);
            chk($sformatf("vec%0d_err", i), {m1_err_o, m0_err_o}, 2'b00);
            if (i == 1) begin
                chk("vec1_sdata", s_data_o, 64'hDEAD);
                chk("vec1_swe", s_we_o, 1'b1);
                chk("vec1_rdata", {m0_data_o, m1_data_o}, {64'h1234_5678, 64'h1234_5678});
            end
            step();
        end

        // timeout: m0 stalls for TO beats, then aborts
        drive(0, 2'b01, 2'b01, 0);
        @(negedge clk); chk("to_idle", grant_o, 2'b00); step();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), {grant_o, s_cyc_o, m0_err_o}, {2'b01, 1'b1, 1'b0});
            step();
        end
        drive(0, 2'b11, 2'b11, 1);
        @(negedge clk);
        chk("to_err_pulse", {m0_err_o, m1_err_o}, 2'b10);
        chk("to_abort_slave", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}, 4'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("to_hold%0d", k), {m0_err_o, s_cyc_o, m0_ack_o, grant_o[1]}, 4'b0);
            step();
        end
        drive(0, 2'b10, 2'b10, 0);
        @(negedge clk); chk("to_release", {s_cyc_o, grant_o[1], m0_err_o}, 3'b0); step();
        @(negedge clk); chk("to_idle2", grant_o, 2'b00); step();
        @(negedge clk); chk("to_m1_grant", {grant_o, s_cyc_o, s_addr_o}, {2'b10, 1'b1, 32'h20}); step();
        drive(0, 2'b00, 2'b00, 0);
        step(); step();

        // ack on the expiry beat completes normally
        drive(0, 2'b01, 2'b01, 0);
        step();
        for (int k = 0; k < TO - 1; k++) step();
        s_ack = 1;
        @(negedge clk);
        chk("bnd_ack", {m0_ack_o, m0_err_o, grant_o}, {1'b1, 1'b0, 2'b01});
        step();
        s_ack = 0;
        @(negedge clk);
        chk("bnd_after", {m0_err_o, grant_o, s_cyc_o}, {1'b0, 2'b01, 1'b1});
        step();
        drive(0, 2'b00, 2'b00, 0);
        step(); step();

        // randomized run against the reference model
        drive(1, 2'b00, 2'b00, 0);
        step();
        m_own = -1; m_last = 1; m_wait = 0; m_abt = 0; m_err = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [1:0]    e_grant, e_ack;
            logic          e_cyc, e_stb, e_we;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_dat;
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 7) == 0) cyc[m] = ~cyc[m];
                stb[m]  = cyc[m] & ($urandom_range(0, 3) != 0);
                we[m]   = 1'($urandom);
                addr[m] = $urandom;
                wdat[m] = {$urandom, $urandom};
            end
            s_ack  = ($urandom_range(0, 4) == 0);
            s_rdat = {$urandom, $urandom};
            rst    = ($urandom_range(0, 299) == 0);

            e_grant = 2'b00; e_ack = 2'b00;
            e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_dat = '0;
            if (m_own >= 0) begin
                e_grant = (m_own == 0) ? 2'b01 : 2'b10;
                if (!m_abt) begin
                    e_cyc  = cyc[m_own];
                    e_stb  = stb[m_own];
                    e_we   = we[m_own];
                    e_addr = addr[m_own];
                    e_dat  = wdat[m_own];
                    e_ack[m_own] = s_ack;
                end
            end
            @(negedge clk);
            chk($sformatf("rand%0d", n),
                {grant_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
                 m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, m0_data_o, m1_data_o},
                {e_grant, e_cyc, e_stb, e_we, e_addr, e_dat,
                 e_ack, m_err, s_rdat, s_rdat});

            m_err = 2'b00;
            if (rst) begin
                m_own = -1; m_last = 1; m_wait = 0; m_abt = 0;
            end else if (m_own < 0) begin
                if (cyc == 2'b11) m_own = 1 - m_last;
                else if (cyc[0]) m_own = 0;
                else if (cyc[1]) m_own = 1;
                if (m_own >= 0) begin
                    m_last = m_own;
                    m_wait = 0;
                end
            end else if (!cyc[m_own]) begin
                m_own = -1; m_abt = 0; m_wait = 0;
            end else if (!m_abt) begin
                if (stb[m_own] && !s_ack) begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_abt = 1;
                        m_err[m_own] = 1'b1;
                        m_wait = 0;
                    end
                end else begin
                    m_wait = 0;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
